// File: rtl/dt_pack.sv
// Distance-map thresholder: streams 16*NWORDS bytes from the result RAM,
// thresholds each against a latched level and packs pixels MSB-first into 16-bit image words.
module dt_pack #(
    parameter int unsigned NWORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  thr,
    output logic        res_rd,
    output logic [13:0] res_addr,
    input  logic [7:0]  res_di,
    output logic        img_wr,
    output logic [9:0]  img_addr,
    output logic [15:0] img_do,
    output logic        busy,
    output logic        done,
    output logic [14:0] ones_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    localparam logic [13:0] LAST_RD   = 14'(16 * NWORDS - 1);
    localparam logic [9:0]  LAST_WORD = 10'(NWORDS - 1);
    localparam logic [14:0] ONES_MAX  = 15'd16384;

    state_t      state_q, state_d;
    logic [7:0]  thr_q, thr_d;
    logic        res_rd_q, res_rd_d;
    logic [13:0] res_addr_q, res_addr_d;
    logic        cap_vld_q, cap_vld_d;
    logic [13:0] cap_idx_q, cap_idx_d;
    logic [14:0] pack_q, pack_d;
    logic        img_wr_q, img_wr_d;
    logic [9:0]  img_addr_q, img_addr_d;
    logic [15:0] img_do_q, img_do_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [14:0] ones_q, ones_d;
    logic        pix;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            thr_q      <= '0;
            res_rd_q   <= 1'b0;
            res_addr_q <= '0;
            cap_vld_q  <= 1'b0;
            cap_idx_q  <= '0;
            pack_q     <= '0;
            img_wr_q   <= 1'b0;
            img_addr_q <= '0;
            img_do_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ones_q     <= '0;
        end else begin
            state_q    <= state_d;
            thr_q      <= thr_d;
            res_rd_q   <= res_rd_d;
            res_addr_q <= res_addr_d;
            cap_vld_q  <= cap_vld_d;
            cap_idx_q  <= cap_idx_d;
            pack_q     <= pack_d;
            img_wr_q   <= img_wr_d;
            img_addr_q <= img_addr_d;
            img_do_q   <= img_do_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ones_q     <= ones_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        thr_d      = thr_q;
        res_rd_d   = res_rd_q;
        res_addr_d = res_addr_q;
        pack_d     = pack_q;
        img_wr_d   = 1'b0;
        img_addr_d = img_addr_q;
        img_do_d   = img_do_q;
        busy_d     = busy_q;
        done_d     = done_q;
        ones_d     = ones_q;

        // Read data arrives one cycle after its strobe, so the read address is delayed alongside it.
        cap_vld_d  = res_rd_q;
        cap_idx_d  = res_addr_q;
        pix        = cap_vld_q && (res_di >= thr_q);

        if (cap_vld_q) begin
            pack_d = {pack_q[13:0], pix};
            if (pix && (ones_q != ONES_MAX)) begin
                ones_d = ones_q + 15'd1;
            end
            if (cap_idx_q[3:0] == 4'hF) begin
                img_wr_d   = 1'b1;
                img_addr_d = cap_idx_q[13:4];
                img_do_d   = {pack_q, pix};
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = RUN;
                    thr_d      = thr;
                    ones_d     = '0;
                    done_d     = 1'b0;
                    pack_d     = '0;
                    busy_d     = 1'b1;
                    res_rd_d   = 1'b1;
                    res_addr_d = '0;
                end
            end
            RUN: begin
                if (res_addr_q == LAST_RD) begin
                    res_rd_d = 1'b0;
                    state_d  = FLUSH;
                end else begin
                    res_addr_d = res_addr_q + 14'd1;
                end
            end
            FLUSH: begin
                if (img_wr_q && (img_addr_q == LAST_WORD)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign res_rd   = res_rd_q;
    assign res_addr = res_addr_q;
    assign img_wr   = img_wr_q;
    assign img_addr = img_addr_q;
    assign img_do   = img_do_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ones_cnt = ones_q;

endmodule

// File: tb/tb_dt_pack.sv
// Directed bench for dt_pack: a registered result-RAM model, per-word write checks
// against a pixel model, and hand-computed first-word / ones-count expectations.
module tb_dt_pack;

    localparam int unsigned NW   = 64;
    localparam int unsigned NPIX = 16 * NW;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        start  = 1'b0;
    logic [7:0]  thr    = '0;
    logic        res_rd;
    logic [13:0] res_addr;
    logic [7:0]  res_di = '0;
    logic        img_wr;
    logic [9:0]  img_addr;
    logic [15:0] img_do;
    logic        busy;
    logic        done;
    logic [14:0] ones_cnt;

    dt_pack #(.NWORDS(NW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .thr      (thr),
        .res_rd   (res_rd),
        .res_addr (res_addr),
        .res_di   (res_di),
        .img_wr   (img_wr),
        .img_addr (img_addr),
        .img_do   (img_do),
        .busy     (busy),
        .done     (done),
        .ones_cnt (ones_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [0:16383];
    always @(posedge clk) if (res_rd) res_di <= mem[res_addr];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_word(input int unsigned k, input logic [7:0] th);
        logic [15:0] w;
        w = '0;
        for (int unsigned j = 0; j < 16; j++) w[15-j] = (mem[(16*k+j) % 16384] >= th);
        return w;
    endfunction

    function automatic int unsigned model_ones(input logic [7:0] th);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < NPIX; i++) if (mem[i] >= th) n++;
        return n;
    endfunction

    task automatic clear_map();
        for (int unsigned i = 0; i < 16384; i++) mem[i] = '0;
    endtask

    task automatic random_map();
        clear_map();
        for (int unsigned i = 0; i < NPIX; i++) mem[i] = 8'($urandom_range(0, 255));
    endtask

    // Called at a falling edge; start is accepted on the next rising edge (cycle T).
    task automatic do_run(input logic [7:0] th, input logic [15:0] exp_w0,
                          input int unsigned exp_ones, input int unsigned hold_at);
        int unsigned k;
        int          t0;
        logic [15:0] w0;
        k     = 0;
        w0    = 'x;
        start = 1'b1;
        thr   = th;
        t0    = cyc;
        for (int unsigned m = 1; m <= NPIX + 3; m++) begin
            @(negedge clk);
            if (m == 1) begin
                start = 1'b0;
                thr   = ~th;
                check("first_cycle", {busy, done, res_rd, res_addr, ones_cnt},
                      {1'b1, 1'b0, 1'b1, 14'd0, 15'd0});
            end
            if (hold_at != 0 && m == hold_at) start = 1'b1;
            if (img_wr) begin
                check("wr_addr", 64'(img_addr), 64'(k));
                check("wr_data", 64'(img_do), 64'(model_word(k, th)));
                check("wr_time", 64'(cyc - t0), 64'(16 * k + 18));
                if (k == 0) w0 = img_do;
                k++;
            end
            if (m == NPIX)     check("last_read", {res_rd, res_addr}, {1'b1, 14'(NPIX - 1)});
            if (m == NPIX + 1) check("rd_off", 64'(res_rd), 64'd0);
            if (m == NPIX + 2) check("pre_done", {busy, done}, 2'b10);
            if (m == NPIX + 3) begin
                check("done_edge", {busy, done}, 2'b01);
                check("ones_cnt", 64'(ones_cnt), 64'(exp_ones));
                check("word_count", 64'(k), 64'(NW));
                check("word0", 64'(w0), 64'(exp_w0));
            end
        end
    endtask

    initial begin
        int busy_seen;
        clear_map();
        #1;
        check("reset_state", {res_rd, res_addr, img_wr, img_addr, img_do, busy, done, ones_cnt}, '0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle", {busy, done, img_wr, res_rd}, 4'b0000);

        // All-zero map, thr=1
        do_run(8'd1, 16'h0000, 0, 0);
        @(negedge clk);
        check("done_hold", {busy, done, img_wr}, 3'b010);

        // Single set pixel at address 0
        mem[0] = 8'd1;
        do_run(8'd1, 16'h8000, 1, 0);

        // Ramp 0..15 in word 0 against thr=8
        clear_map();
        for (int unsigned j = 0; j < 16; j++) mem[j] = 8'(j);
        do_run(8'd8, 16'h00FF, 8, 0);

        // thr=0 sets every pixel
        random_map();
        do_run(8'd0, 16'hFFFF, NPIX, 0);

        // thr=255 only hits exact 255
        clear_map();
        mem[1]  = 8'd255;
        mem[2]  = 8'd254;
        mem[17] = 8'd255;
        do_run(8'd255, 16'h4000, 2, 0);

        // General random map
        random_map();
        do_run(8'h80, model_word(0, 8'h80), model_ones(8'h80), 0);

        // Reset 100 cycles into a run
        @(negedge clk);
        start = 1'b1;
        thr   = 8'h40;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        check("mid_run_busy", {busy, res_rd}, 2'b11);
        reset = 1'b1;
        #1;
        check("async_reset", {res_rd, res_addr, img_wr, img_addr, img_do, busy, done, ones_cnt}, '0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        busy_seen = 0;
        for (int unsigned i = 0; i < 40; i++) begin
            @(negedge clk);
            if (img_wr || busy || res_rd) busy_seen++;
        end
        check("post_reset_quiet", 64'(busy_seen), 64'd0);
        do_run(8'h40, model_word(0, 8'h40), model_ones(8'h40), 0);

        // Start asserted at T+50 and held: one run, then a back-to-back run from DONE
        @(negedge clk);
        do_run(8'h40, model_word(0, 8'h40), model_ones(8'h40), 50);
        check("restart_held", 64'(start), 64'd1);
        do_run(8'h40, model_word(0, 8'h40), model_ones(8'h40), 0);
        @(negedge clk);
        check("final_done", {busy, done}, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dt_pack.md
DT_PACK -- requirements
Module: dt_pack

Interface
REQ-001 The block SHALL have parameter NWORDS, default 1024, giving the number of 16-bit image words to produce (legal range 1..1024).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: run request, sampled only in IDLE or DONE.
REQ-005 The block SHALL have port thr, input, 8 bits: pixel threshold, latched on accepted start.
REQ-006 The block SHALL have port res_rd, output, 1 bit: distance-map RAM read strobe.
REQ-007 The block SHALL have port res_addr, output, 14 bits: distance-map RAM read address.
REQ-008 The block SHALL have port res_di, input, 8 bits: distance-map read data, valid the cycle after res_rd=1.
REQ-009 The block SHALL have port img_wr, output, 1 bit: image memory write strobe, one cycle per word.
REQ-010 The block SHALL have port img_addr, output, 10 bits: image word address.
REQ-011 The block SHALL have port img_do, output, 16 bits: packed image word.
REQ-012 The block SHALL have port busy, output, 1 bit: run in progress.
REQ-013 The block SHALL have port done, output, 1 bit: run complete; level, held until the next accepted start.
REQ-014 The block SHALL have port ones_cnt, output, 15 bits: count of pixels set to 1 in the current or last run.
REQ-015 All outputs SHALL be registered.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, FLUSH and DONE.
- IDLE->RUN on start=1.
- RUN->FLUSH after the read of address 16*NWORDS-1 is issued.
- FLUSH->DONE after the final word write.
- DONE->RUN on start=1.
REQ-017 An accepted start in cycle T SHALL:
- latch thr;
- clear ones_cnt, done and the bit packer;
- assert busy from cycle T+1.
REQ-018 Reads SHALL run at one per cycle:
- res_rd=1 in cycles T+1..T+16*NWORDS;
- res_addr=0 in cycle T+1, incrementing by 1 each cycle;
- res_rd=0 otherwise.
REQ-019 Pixel a SHALL be captured from res_di in the cycle after its read is issued; pixel bit = 1 iff res_di >= latched thr (unsigned 8-bit compare).
REQ-020 Pixel 16k+j SHALL map to img_do bit 15-j of word k (MSB first).
REQ-021 Word k SHALL be written with img_wr=1, img_addr=k and img_do=packed bits in cycle T+16k+18, for exactly one cycle; img_wr SHALL be 0 in all other cycles.
REQ-022 img_do and img_addr SHALL hold their last values while img_wr=0.
REQ-023 ones_cnt SHALL increment by 1 per captured 1-pixel (maximum 16384, no wrap) and is final when done rises.
REQ-024 busy SHALL fall and done SHALL rise at cycle T+16*NWORDS+3.
REQ-025 start=1 while busy=1 SHALL be ignored with no effect on the run.
REQ-026 start held high SHALL not retrigger until DONE is reached; start=1 in DONE SHALL begin a new run.
REQ-027 thr=0 SHALL yield all-ones words; thr=255 SHALL set only pixels equal to 255.

Reset
REQ-028 On reset=1 the block SHALL immediately, without waiting for a clock edge:
- enter IDLE;
- drive res_rd=0, res_addr=0, img_wr=0, img_addr=0, img_do=0, busy=0, done=0, ones_cnt=0;
- clear the latched thr and the packer.
REQ-029 Reset asserted mid-run SHALL abort the run; no img_wr pulse SHALL occur until a new start is accepted after reset is released.

Verification
REQ-030 All-zero map, thr=1, NWORDS=1024 -> 1024 writes of 16'h0000 to addresses 0..1023, ones_cnt=0, done at T+16387.
REQ-031 res[0]=1, all others 0, thr=1 -> word0=16'h8000, all other words 16'h0000, ones_cnt=1.
REQ-032 res[j]=j for j=0..15, thr=8 -> word0=16'h00FF, ones_cnt=8 (remaining map zero).
REQ-033 thr=0, any map -> every word 16'hFFFF, ones_cnt=16384.
REQ-034 Reset pulsed at T+100 -> all outputs 0 asynchronously, no further writes; a new start then produces a clean, complete run with correct timing.
REQ-035 start asserted at T+50 and held through the run -> a single run only, identical output; a new run begins one cycle after DONE is entered while start=1.
